sha256_round_ctrl: RTL and testbench
====================================

// Module: sha256_round_ctrl
// PURPOSE
//  Sequences one SHA-256 compression per 512-bit block: 64 rounds at one round per cycle, message
//  schedule, chaining across multi-block messages, final digest. Sits between the padder/block
//  source (upstream) and the digest consumer (downstream); all round math comes from sha256_pkg.
// PARAMETERS
//  MSG_BITS   512  input block width (fixed; 16 x WORD_SIZE)
//  DIG_BITS   256  digest width (= sha256_pkg::BLOCK_SIZE)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    block on in_block is valid
//  in_ready   out  1    controller can accept a block
//  in_block   in   512  padded block, word 0 = in_block[511:480] (big-endian word order)
//  in_first   in   1    block starts a new message (chain := H init)
//  in_last    in   1    block ends message (digest is produced)
//  out_valid  out  1    digest valid
//  out_ready  in   1    consumer takes digest
//  digest     out  256  H0..H7, H0 in [255:224]
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, digest=0, busy=0, round ctr=0, chain regs=H[0..7].
//  FSM: IDLE -> ROUND -> FINAL -> (DONE if last else IDLE); DONE -> IDLE on out_valid&&out_ready.
//  Accept only in IDLE: in_ready = (state==IDLE). Transfer on in_valid&&in_ready at cycle T:
//   - W window[0..15] <= in_block words; in_last latched; if in_first, chain regs <= H[0..7] and
//     a..h <= H[0..7], else a..h <= current chain regs. state <= ROUND, ctr <= 0.
//  ROUND (cycles T+1..T+64, round t at T+1+t): W_t = window[0]; T1=h+sum1(e)+Ch(e,f,g)+K[t]+W_t;
//   T2=sum0(a)+Maj(a,b,c); standard a..h shift. Window shifts left by one, new window[15] =
//   sigma1(w[14])+w[9]+sigma0(w[1])+w[0]. All adds mod 2^32 (truncate, no carry out).
//   ctr==63 -> FINAL.
//  FINAL (T+65): chain[i] <= chain[i] + {a..h}[i] mod 2^32. If last: digest <= sums, state <= DONE
//   (out_valid=1 from T+66). Else state <= IDLE (in_ready=1 from T+66). Throughput: 1 block / 66 clk.
//  DONE: out_valid, digest held stable until out_ready; in_ready=0. Handshake in same cycle
//   out_valid rises is legal; returns to IDLE next cycle. digest holds last value after handshake.
//  Boundaries:
//   - in_first&&in_last: single-block message.
//   - in_first=0 as first block after reset: chains from reset value H (identical to in_first=1).
//   - in_first=1 mid-message: restarts chain, prior partial message silently discarded.
//   - in_valid while busy: ignored (no accept), upstream must hold per valid/ready rules.
//   - out_ready high with out_valid low: no effect.
//   - rst mid-round or in DONE: immediate return to reset values; pending digest lost.
//  in_block/in_first/in_last sampled only at the accept edge; may change after.
// STRUCTURE
//  sha256_pkg: K[], H[], sigma0/1, sum0/1, Ch, Maj (existing); add state enum
//   typedef enum logic [1:0] {S_IDLE,S_ROUND,S_FINAL,S_DONE} sha256_ctrl_state_t and
//   localparam MSG_WORDS=16.
//  One sub-module: sha256_msg_sched (16-word shift window, load/shift, presents W_t) instantiated
//   once; round logic, counter and FSM inline.
// TESTING
//  "abc": block 61626380,0x0 x14,00000018, first=1,last=1 -> out_valid at T+66,
//   digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//  Empty msg: block 80000000, zeros -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
//  Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (blk1 first, blk2 last) ->
//   no out_valid after blk1, in_ready back at T+66; final digest
//   248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
//  Back-pressure: out_ready=0 for 20 cycles after "abc" -> digest stable, in_ready=0, new
//   in_valid not accepted; accept occurs the cycle after out_ready handshake.
//  "abc" then new in_first "abc" without reset -> identical digest (chain restart works).
//  rst pulse at round 30 -> all outputs at reset values; subsequent "abc" gives correct digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 constants, round helper functions and controller state encoding.
package sha256_pkg;

    localparam int unsigned WORD_SIZE  = 32;
    localparam int unsigned MSG_WORDS  = 16;
    localparam int unsigned MSG_BITS   = MSG_WORDS * WORD_SIZE;
    localparam int unsigned BLOCK_SIZE = 8 * WORD_SIZE;
    localparam int unsigned NUM_ROUNDS = 64;
    localparam int unsigned CTR_W      = 6;

    typedef logic [WORD_SIZE-1:0] word_t;

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} sha256_ctrl_state_t;

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t H [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_SIZE - n));
    endfunction

    function automatic word_t sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t sum0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t sum1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Block-in / digest-out handshake bundle for the SHA-256 round controller.
interface sha256_round_ctrl_if;
    import sha256_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [MSG_BITS-1:0]   in_block;
    logic                  in_first;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [BLOCK_SIZE-1:0] digest;
    logic                  busy;

    modport master (
        output in_valid, in_block, in_first, in_last, out_ready,
        input  in_ready, out_valid, digest, busy
    );

    modport slave (
        input  in_valid, in_block, in_first, in_last, out_ready,
        output in_ready, out_valid, digest, busy
    );

endinterface

// File: rtl/sha256_msg_sched.sv
// 16-word message schedule window; w_t is always the word for the current round.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                shift,
    input  logic [MSG_BITS-1:0] block,
    output word_t               w_t
);

    word_t win [MSG_WORDS];
    word_t w_new;

    always_comb begin
        w_new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
    end

    // Word 0 of the block lives in the top bits (big-endian word order).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSG_WORDS; i++) win[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < MSG_WORDS; i++)
                win[i] <= block[(MSG_WORDS-1-i)*WORD_SIZE +: WORD_SIZE];
        end else if (shift) begin
            for (int i = 0; i < MSG_WORDS-1; i++) win[i] <= win[i+1];
            win[MSG_WORDS-1] <= w_new;
        end
    end

    assign w_t = win[0];

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: one round per cycle, chaining across blocks, digest hand-off.
module sha256_round_ctrl
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    sha256_round_ctrl_if.slave bus
);

    sha256_ctrl_state_t    state;
    logic [CTR_W-1:0]      ctr;
    logic                  last_q;
    word_t                 chain [8];
    word_t                 st [8];
    word_t                 w_t;
    word_t                 t1;
    word_t                 t2;
    logic [BLOCK_SIZE-1:0] sums;
    logic                  accept;
    logic                  shift;

    assign accept = (state == S_IDLE) && bus.in_valid;
    assign shift  = (state == S_ROUND);

    sha256_msg_sched u_sched (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift),
        .block (bus.in_block),
        .w_t   (w_t)
    );

    // Round temporaries and the chained sums packed H0-first.
    always_comb begin
        sums = '0;
        t1   = st[7] + sum1(st[4]) + ch(st[4], st[5], st[6]) + K[ctr] + w_t;
        t2   = sum0(st[0]) + maj(st[0], st[1], st[2]);
        for (int i = 0; i < 8; i++)
            sums[(7-i)*WORD_SIZE +: WORD_SIZE] = chain[i] + st[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            ctr           <= '0;
            last_q        <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.digest    <= '0;
            bus.busy      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                chain[i] <= H[i];
                st[i]    <= H[i];
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        last_q       <= bus.in_last;
                        ctr          <= '0;
                        state        <= S_ROUND;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        // A first block restarts the chain, dropping any partial message.
                        for (int i = 0; i < 8; i++) begin
                            if (bus.in_first) begin
                                chain[i] <= H[i];
                                st[i]    <= H[i];
                            end else begin
                                st[i]    <= chain[i];
                            end
                        end
                    end
                end
                S_ROUND: begin
                    st[0] <= t1 + t2;
                    st[1] <= st[0];
                    st[2] <= st[1];
                    st[3] <= st[2];
                    st[4] <= st[3] + t1;
                    st[5] <= st[4];
                    st[6] <= st[5];
                    st[7] <= st[6];
                    ctr   <= ctr + CTR_W'(1);
                    if (ctr == CTR_W'(NUM_ROUNDS - 1)) state <= S_FINAL;
                end
                S_FINAL: begin
                    for (int i = 0; i < 8; i++) chain[i] <= chain[i] + st[i];
                    if (last_q) begin
                        bus.digest    <= sums;
                        bus.out_valid <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed-vector bench for sha256_round_ctrl using known SHA-256 digests.
module tb_sha256_round_ctrl;
    import sha256_pkg::*;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sha256_round_ctrl_if bus ();

    sha256_round_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  256'(bus.in_ready),  256'(1));
        check({tag, "_out_valid"}, 256'(bus.out_valid), 256'(0));
        check({tag, "_busy"},      256'(bus.busy),      256'(0));
    endtask

    // Present a block until the accept edge, then scramble the inputs.
    task automatic send(input logic [511:0] blk, input logic first, input logic last);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        check("send_ready", 256'(bus.in_ready), 256'(1));
        bus.in_valid = 1'b1;
        bus.in_block = blk;
        bus.in_first = first;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_block = ~blk;
        bus.in_first = ~first;
        bus.in_last  = ~last;
        check("accept_busy_ready", 256'({bus.busy, bus.in_ready}), 256'(2'b10));
    endtask

    task automatic wait_digest(input string tag, input logic [255:0] exp);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 256'(n), 256'(65));
        check({tag, "_digest"},  bus.digest, exp);
    endtask

    task automatic wait_chain(input string tag);
        int   n = 0;
        logic seen_ov = 1'b0;
        while (!bus.in_ready && n < 100) begin
            tick();
            seen_ov = seen_ov | bus.out_valid;
            n++;
        end
        check({tag, "_latency"}, 256'(n), 256'(65));
        check({tag, "_no_out_valid"}, 256'(seen_ov), 256'(0));
    endtask

    task automatic take_digest(input string tag, input logic [255:0] exp);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_idle({tag, "_after_hs"});
        check({tag, "_hold"}, bus.digest, exp);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        #2 rst = 1'b1;
        tick();
        tick();
        check_idle("reset");
        check("reset_digest", bus.digest, 256'h0);
        rst = 1'b0;
        tick();

        // out_ready with nothing pending does nothing; kept high so the handshake lands as out_valid rises
        bus.out_ready = 1'b1;
        tick();
        check_idle("idle_out_ready");
        send(BLK_ABC, 1'b1, 1'b1);
        wait_digest("abc", DIG_ABC);
        tick();
        bus.out_ready = 1'b0;
        check_idle("abc_same_cycle_hs");
        check("abc_hold", bus.digest, DIG_ABC);

        send(BLK_TWO1, 1'b1, 1'b0);
        wait_chain("two_blk1");
        send(BLK_TWO2, 1'b0, 1'b1);
        wait_digest("two", DIG_TWO);

        // Back-pressure: a new block is offered while the digest is pending
        bus.in_valid = 1'b1;
        bus.in_block = BLK_EMPTY;
        bus.in_first = 1'b1;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_digest",    bus.digest,               DIG_TWO);
            check("bp_out_valid", 256'(bus.out_valid),      256'(1));
            check("bp_in_ready",  256'(bus.in_ready),       256'(0));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_idle("bp_hs");
        tick();
        bus.in_valid = 1'b0;
        check("bp_accept", 256'({bus.busy, bus.in_ready}), 256'(2'b10));
        wait_digest("empty", DIG_EMPTY);
        take_digest("empty", DIG_EMPTY);

        send(BLK_ABC, 1'b1, 1'b1);
        wait_digest("abc_again", DIG_ABC);
        take_digest("abc_again", DIG_ABC);

        send(BLK_TWO1, 1'b1, 1'b0);
        wait_chain("restart_blk1");
        send(BLK_ABC, 1'b1, 1'b1);
        wait_digest("restart", DIG_ABC);
        take_digest("restart", DIG_ABC);

        // Reset during round 30 must abandon the block immediately
        send(BLK_ABC, 1'b1, 1'b1);
        repeat (30) tick();
        #2 rst = 1'b1;
        #1;
        check_idle("midround_rst");
        check("midround_rst_digest", bus.digest, 256'h0);
        tick();
        rst = 1'b0;
        tick();
        send(BLK_ABC, 1'b0, 1'b1);
        wait_digest("post_rst", DIG_ABC);
        take_digest("post_rst", DIG_ABC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
